// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave exposing NUM_REGS word-wide registers with byte strobes.
// The AW and W channels are buffered independently; reads complete in one cycle.
module axi_lite_regfile #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic                           AWVALID,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic [2:0]                     AWPROT,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic [2:0]                     ARPROT,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

    localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned LSB         = $clog2(STRB_WIDTH);
    localparam int unsigned IDX_WIDTH   = $clog2(NUM_REGS);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    // Whole-address compare also rejects any set bit above the index field.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] idx;
        idx = addr >> LSB;
        return idx < ADDR_WIDTH'(NUM_REGS);
    endfunction

    function automatic logic [IDX_WIDTH-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] idx;
        idx = addr >> LSB;
        return idx[IDX_WIDTH-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  aw_full_q, aw_full_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                  w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  commit;
    logic                  unused_prot;

    assign unused_prot = ^{AWPROT, ARPROT};

    assign AWREADY = !aw_full_q && !ARESET;
    assign WREADY  = !w_full_q && !ARESET;
    assign ARREADY = !rvalid_q && !ARESET;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign RVALID  = rvalid_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;

    assign commit = aw_full_q && w_full_q && !bvalid_q;

    always_comb begin
        regs_d    = regs_q;
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;

        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (addr_in_range(aw_addr_q)) begin
                bresp_d = RESP_OKAY;
                for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
                    if (w_strb_q[b]) begin
                        regs_d[addr_index(aw_addr_q)][8*b +: 8] = w_data_q[8*b +: 8];
                    end
                end
            end else begin
                bresp_d = RESP_SLVERR;
            end
        end else if (bvalid_q && BREADY) begin
            bvalid_d = 1'b0;
        end

        // A buffer being filled is never the one being drained on the same edge.
        if (AWVALID && AWREADY) begin
            aw_full_d = 1'b1;
            aw_addr_d = AWADDR;
        end
        if (WVALID && WREADY) begin
            w_full_d = 1'b1;
            w_data_d = WDATA;
            w_strb_d = WSTRB;
        end

        // Reads sample regs_q, so a same-edge commit is not visible.
        if (ARVALID && ARREADY) begin
            rvalid_d = 1'b1;
            if (addr_in_range(ARADDR)) begin
                rdata_d = regs_q[addr_index(ARADDR)];
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end
        end else if (rvalid_q && RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            regs_q    <= '{default: '0};
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            regs_q    <= regs_d;
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile: each task drives one scenario and checks inline.
// Inputs change and outputs are sampled on the falling edge.
module tb_axi_lite_regfile;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;

    logic          ACLK;
    logic          ARESET;
    logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic          ARVALID, ARREADY, RVALID, RREADY;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [2:0]    AWPROT, ARPROT;
    logic [DW-1:0] WDATA, RDATA;
    logic [3:0]    WSTRB;
    logic [1:0]    BRESP, RRESP;
    logic [NR*DW-1:0] reg_out;

    logic [DW-1:0] exp_regs [NR];
    int n_checks = 0;
    int n_fail   = 0;

    axi_lite_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWVALID(AWVALID), .AWADDR(AWADDR), .AWPROT(AWPROT), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .reg_out(reg_out)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(negedge ACLK);
    endtask

    function automatic logic [NR*DW-1:0] exp_vec();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = exp_regs[i];
        return v;
    endfunction

    task automatic ack_b();
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
    endtask

    task automatic ack_r();
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {AWREADY, WREADY, ARREADY, BVALID, RVALID});
        end
        n_checks++;
        if (reg_out !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got %h want 0", reg_out);
        end
        ARESET = 1'b0;
        tick();
        n_checks++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 111", {AWREADY, WREADY, ARREADY});
        end
    endtask

    task automatic test_write_read();
        AWVALID = 1'b1; AWADDR = 32'h8;
        WVALID = 1'b1; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        n_checks++;
        if (BVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_early_bvalid: got %b want 0", BVALID);
        end
        tick();
        exp_regs[2] = 32'hDEAD_BEEF;
        n_checks++;
        if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
            n_fail++;
            $display("FAIL wr_bresp: got bvalid=%b bresp=%0d want 1/0", BVALID, BRESP);
        end
        ack_b();
        n_checks++;
        if (BVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_bclear: got %b want 0", BVALID);
        end
        ARVALID = 1'b1; ARADDR = 32'h8;
        tick();
        ARVALID = 1'b0;
        n_checks++;
        if (RVALID !== 1'b1 || RDATA !== 32'hDEAD_BEEF || RRESP !== 2'b00 || ARREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_data: got v=%b d=%h r=%0d ar=%b want 1/deadbeef/0/0",
                     RVALID, RDATA, RRESP, ARREADY);
        end
        ack_r();
        n_checks++;
        if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_clear: got v=%b ar=%b want 0/1", RVALID, ARREADY);
        end
    endtask

    task automatic test_w_before_aw();
        WVALID = 1'b1; WDATA = 32'h1122_3344; WSTRB = 4'h5;
        tick();
        WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (WREADY !== 1'b0 || BVALID !== 1'b0) begin
                n_fail++;
                $display("FAIL wfirst_hold%0d: got wready=%b bvalid=%b want 0/0", i, WREADY, BVALID);
            end
            if (i == 2) begin
                AWVALID = 1'b1; AWADDR = 32'hC;
            end
            tick();
        end
        AWVALID = 1'b0;
        n_checks++;
        if (WREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL wfirst_precommit: got wready=%b want 0", WREADY);
        end
        tick();
        exp_regs[3] = 32'h0022_0044;
        n_checks++;
        if (reg_out !== exp_vec() || BVALID !== 1'b1 || WREADY !== 1'b1) begin
            n_fail++;
            $display("FAIL wfirst_commit: got reg3=%h bvalid=%b wready=%b want 00220044/1/1",
                     reg_out[3*DW +: DW], BVALID, WREADY);
        end
        ack_b();
    endtask

    task automatic test_out_of_range();
        AWVALID = 1'b1; AWADDR = 32'h40;
        WVALID = 1'b1; WDATA = 32'hFFFF_FFFF; WSTRB = 4'hF;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        tick();
        n_checks++;
        if (BVALID !== 1'b1 || BRESP !== 2'b10 || reg_out !== exp_vec()) begin
            n_fail++;
            $display("FAIL oor_write: got bvalid=%b bresp=%0d regs_changed=%b want 1/2/0",
                     BVALID, BRESP, reg_out !== exp_vec());
        end
        ack_b();
        ARVALID = 1'b1; ARADDR = 32'h1000_0000;
        tick();
        ARVALID = 1'b0;
        n_checks++;
        if (RVALID !== 1'b1 || RDATA !== 32'h0 || RRESP !== 2'b10) begin
            n_fail++;
            $display("FAIL oor_read: got v=%b d=%h r=%0d want 1/0/2", RVALID, RDATA, RRESP);
        end
        ack_r();
    endtask

    task automatic test_back_to_back();
        int aw_cnt = 0;
        int w_cnt  = 0;
        int bad    = 0;
        AWVALID = 1'b1; AWADDR = 32'h14;
        WVALID = 1'b1; WDATA = 32'hA5A5_A5A5; WSTRB = 4'hF;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        tick();
        exp_regs[5] = 32'hA5A5_A5A5;
        AWVALID = 1'b1; AWADDR = 32'h18;
        WVALID = 1'b1; WDATA = 32'h1234_5678; WSTRB = 4'hF;
        for (int i = 0; i < 5; i++) begin
            if (BVALID !== 1'b1 || BRESP !== 2'b00) bad++;
            if (AWVALID && AWREADY) aw_cnt++;
            if (WVALID && WREADY) w_cnt++;
            tick();
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL b2b_bstable: got %0d unstable cycles want 0", bad);
        end
        n_checks++;
        if (aw_cnt != 1 || w_cnt != 1) begin
            n_fail++;
            $display("FAIL b2b_accept: got aw=%0d w=%0d want 1/1", aw_cnt, w_cnt);
        end
        n_checks++;
        if (reg_out !== exp_vec() || BVALID !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_stall: got reg6=%h bvalid=%b want 0/1", reg_out[6*DW +: DW], BVALID);
        end
        ack_b();
        n_checks++;
        if (BVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_bclear: got %b want 0", BVALID);
        end
        tick();
        exp_regs[6] = 32'h1234_5678;
        n_checks++;
        if (reg_out !== exp_vec() || BVALID !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: got reg6=%h bvalid=%b want 12345678/1",
                     reg_out[6*DW +: DW], BVALID);
        end
        ack_b();
    endtask

    task automatic test_read_during_commit();
        AWVALID = 1'b1; AWADDR = 32'h8;
        WVALID = 1'b1; WDATA = 32'h5; WSTRB = 4'hF;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        tick();
        ack_b();
        exp_regs[2] = 32'h5;
        AWVALID = 1'b1; AWADDR = 32'h8;
        WVALID = 1'b1; WDATA = 32'h9;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        ARVALID = 1'b1; ARADDR = 32'h8;
        tick();
        ARVALID = 1'b0;
        exp_regs[2] = 32'h9;
        n_checks++;
        if (RDATA !== 32'h5 || RVALID !== 1'b1) begin
            n_fail++;
            $display("FAIL rdc_old: got v=%b d=%h want 1/5", RVALID, RDATA);
        end
        n_checks++;
        if (reg_out !== exp_vec() || BVALID !== 1'b1) begin
            n_fail++;
            $display("FAIL rdc_commit: got reg2=%h bvalid=%b want 9/1", reg_out[2*DW +: DW], BVALID);
        end
        ack_r();
        ack_b();
        ARVALID = 1'b1; ARADDR = 32'h8;
        tick();
        ARVALID = 1'b0;
        n_checks++;
        if (RDATA !== 32'h9) begin
            n_fail++;
            $display("FAIL rdc_new: got %h want 9", RDATA);
        end
        ack_r();
    endtask

    task automatic test_reset_midop();
        int bad = 0;
        AWVALID = 1'b1; AWADDR = 32'h10;
        ARVALID = 1'b1; ARADDR = 32'h8;
        tick();
        AWVALID = 1'b0; ARVALID = 1'b0;
        n_checks++;
        if (AWREADY !== 1'b0 || RVALID !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_setup: got awready=%b rvalid=%b want 0/1", AWREADY, RVALID);
        end
        ARESET = 1'b1;
        tick();
        for (int i = 0; i < NR; i++) exp_regs[i] = '0;
        n_checks++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP} !== 9'b0 ||
            RDATA !== '0 || reg_out !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got ctl=%b rdata=%h regs_nz=%b want 0/0/0",
                     {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP}, RDATA,
                     reg_out !== '0);
        end
        ARESET = 1'b0;
        tick();
        n_checks++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            n_fail++;
            $display("FAIL mid_ready: got %b want 111", {AWREADY, WREADY, ARREADY});
        end
        // A lone W must not pair with the discarded AW.
        WVALID = 1'b1; WDATA = 32'hCAFE_F00D; WSTRB = 4'hF;
        tick();
        WVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (BVALID !== 1'b0 || RVALID !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0 || reg_out !== exp_vec()) begin
            n_fail++;
            $display("FAIL mid_noresp: got %0d response cycles regs_nz=%b want 0/0",
                     bad, reg_out !== exp_vec());
        end
    endtask

    initial begin
        ARESET = 1'b1;
        AWVALID = 1'b0; AWADDR = '0; AWPROT = 3'b0;
        WVALID = 1'b0; WDATA = '0; WSTRB = '0;
        BREADY = 1'b0;
        ARVALID = 1'b0; ARADDR = '0; ARPROT = 3'b0;
        RREADY = 1'b0;
        for (int i = 0; i < NR; i++) exp_regs[i] = '0;

        test_reset();
        test_write_read();
        test_w_before_aw();
        test_out_of_range();
        test_back_to_back();
        test_read_during_commit();
        test_reset_midop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
